// File: rtl/periph_pkg.sv
// Shared peripheral definitions: debouncer channel states and default timing.
package periph_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        ARM_PRESS,
        PRESSED,
        ARM_RELEASE
    } btn_state_t;

    // 5 ms of stable input at a 100 MHz system clock.
    localparam int DEFAULT_STABLE_CYCLES = 500000;
    localparam int DEFAULT_SYNC_STAGES   = 2;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: pad synchroniser, stable-sample counter and press/release FSM.
module debounce_channel
    import periph_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int               CW   = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]    ONE  = CW'(1);
    localparam logic [CW-1:0]    LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    btn_state_t    state, state_next;
    logic [CW-1:0] count, count_next;
    logic          level_next, press_next, release_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RELEASED;
            count         <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            level         <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        count_next   = count;
        level_next   = level;
        press_next   = 1'b0;
        release_next = 1'b0;

        case (state)
            RELEASED: begin
                if (sync) begin
                    state_next = ARM_PRESS;
                    count_next = ONE;
                end
            end
            ARM_PRESS: begin
                if (!sync) begin
                    state_next = RELEASED;
                    count_next = '0;
                end else if (count == LAST) begin
                    state_next = PRESSED;
                    count_next = '0;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end else begin
                    count_next = count + ONE;
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_next = ARM_RELEASE;
                    count_next = ONE;
                end
            end
            ARM_RELEASE: begin
                if (sync) begin
                    state_next = PRESSED;
                    count_next = '0;
                end else if (count == LAST) begin
                    state_next   = RELEASED;
                    count_next   = '0;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    count_next = count + ONE;
                end
            end
            default: begin
                state_next = RELEASED;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel pushbutton conditioner; any_press feeds the interrupt FSM press input.
module button_debouncer
    import periph_pkg::*;
#(
    parameter int NUM_BTNS      = 5,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic                any_press
);

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .raw           (btn_raw[g]),
            .level         (btn_level[g]),
            .press_pulse   (btn_press[g]),
            .release_pulse (btn_release[g])
        );
    end

    // Derived only from registered levels, so it cannot glitch.
    assign any_press = |btn_level;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer against a run-length reference model.
module tb_button_debouncer;

    localparam int NB     = 5;
    localparam int STABLE = 4;
    localparam int SYNC   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release;
    logic          any_press;

    button_debouncer #(
        .NUM_BTNS      (NB),
        .STABLE_CYCLES (STABLE),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_press   (any_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [NB-1:0] pr;
        logic [NB-1:0] rl;
    } ev_t;

    ev_t           exp_q[$];
    int            compared   = 0;
    int            mismatched = 0;
    int            cyc        = 0;
    logic [NB-1:0] m_level    = '0;
    int            run[NB];
    logic [NB-1:0] hist[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // Reference model: the raw input becomes visible SYNC edges later; a channel
    // flips once STABLE consecutive visible samples disagree with its level.
    always @(posedge clk) begin
        logic [NB-1:0] seen, pr, rl;
        cyc++;
        if (!rst_n) begin
            m_level = '0;
            hist    = {};
            for (int i = 0; i < SYNC; i++) hist.push_back('0);
            for (int ch = 0; ch < NB; ch++) run[ch] = 0;
        end else begin
            seen = hist.pop_front();
            hist.push_back(btn_raw);
            pr = '0;
            rl = '0;
            for (int ch = 0; ch < NB; ch++) begin
                if (seen[ch] != m_level[ch]) begin
                    run[ch]++;
                    if (run[ch] == STABLE) begin
                        m_level[ch] = seen[ch];
                        pr[ch]      = seen[ch];
                        rl[ch]      = ~seen[ch];
                        run[ch]     = 0;
                    end
                end else begin
                    run[ch] = 0;
                end
            end
            if ((pr | rl) != '0) exp_q.push_back('{cyc: cyc, pr: pr, rl: rl});
        end
    end

    // Monitor: compares levels every cycle and matches each DUT pulse to the next expected event.
    always @(posedge clk) begin
        #1;
        check("btn_level", 32'(btn_level), 32'(m_level));
        check("any_press", 32'(any_press), 32'(|m_level));
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("missed_event_cycle", 32'(cyc), 32'(exp_q[0].cyc));
            void'(exp_q.pop_front());
        end
        if ((btn_press | btn_release) != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({btn_press, btn_release}), 32'(0));
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("btn_press", 32'(btn_press), 32'(e.pr));
                check("btn_release", 32'(btn_release), 32'(e.rl));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int hold[NB];
        // Reset with input held, then release: fresh press on each set bit.
        btn_raw = 5'b10101;
        step(3);
        check("reset_level", 32'(btn_level), 32'(0));
        check("reset_pulses", 32'({btn_press, btn_release, any_press}), 32'(0));
        rst_n = 1'b1;
        step(10);
        btn_raw = '0;
        step(10);
        // Clean press on channel 0.
        btn_raw[0] = 1'b1;
        step(12);
        // Bounce on channel 1, then hold.
        foreach (hold[i]) hold[i] = 0;
        for (int i = 0; i < 6; i++) begin
            logic [5:0] pat;
            pat = 6'b101101;
            btn_raw[1] = pat[5-i];
            step(1);
        end
        step(12);
        // Release both.
        btn_raw = '0;
        step(12);
        // Simultaneous press and release.
        btn_raw = '1;
        step(12);
        btn_raw = '0;
        step(12);
        // Reset mid-count on channel 2.
        btn_raw[2] = 1'b1;
        step(4);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(12);
        btn_raw = '0;
        step(12);
        // Random bouncing with varied hold times and occasional resets.
        for (int i = 0; i < NB; i++) hold[i] = $urandom_range(1, 8);
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < NB; ch++) begin
                hold[ch]--;
                if (hold[ch] <= 0) begin
                    btn_raw[ch] = ~btn_raw[ch];
                    hold[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3)
                                                           : $urandom_range(3, 9);
                end
            end
            rst_n = ($urandom_range(0, 499) != 0);
            step(1);
        end
        rst_n   = 1'b1;
        btn_raw = '0;
        step(20);
        check("events_outstanding", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
